// File: rtl/timer_bridge.sv
// timer_bridge: two memory-mapped countdown timers (timer0 at 0x7F00, timer1
// at 0x7F10) with CTRL/PRESET/COUNT registers and masked interrupt outputs.
module timer_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] oadd,
  input  logic [31:0] ord,
  input  logic        owe,
  output logic [31:0] owd,
  output logic        hit0,
  output logic [5:0]  hwint
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q  [2];
  state_e      state_d  [2];
  logic [3:0]  ctrl_q   [2];
  logic [3:0]  ctrl_d   [2];
  logic [31:0] preset_q [2];
  logic [31:0] preset_d [2];
  logic [31:0] count_q  [2];
  logic [31:0] count_d  [2];
  logic        irq_q    [2];
  logic        irq_d    [2];

  logic        win;
  logic        sel_t;
  logic [1:0]  sel_r;
  logic [1:0]  wr_ctrl;
  logic [1:0]  wr_preset;

  // Address decode: 0x7F00..0x7F1F window, offset 0xC within each timer unmapped
  always_comb begin
    sel_t     = oadd[4];
    sel_r     = oadd[3:2];
    win       = (oadd[31:5] == 27'h3F8) && (oadd[3:2] != 2'd3);
    wr_ctrl   = {owe & win & sel_t & (sel_r == 2'd0),
                 owe & win & ~sel_t & (sel_r == 2'd0)};
    wr_preset = {owe & win & sel_t & (sel_r == 2'd1),
                 owe & win & ~sel_t & (sel_r == 2'd1)};
  end

  assign hit0 = win;

  // Read mux; CTRL upper bits are not stored and read back as zero
  always_comb begin
    owd = 32'd0;
    if (win) begin
      case (sel_r)
        2'd0:    owd = {28'd0, ctrl_q[sel_t]};
        2'd1:    owd = preset_q[sel_t];
        2'd2:    owd = count_q[sel_t];
        default: owd = 32'd0;
      endcase
    end
  end

  assign hwint = {4'd0, irq_q[1] & ctrl_q[1][3], irq_q[0] & ctrl_q[0][3]};

  // FSM state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < 2; t++) state_q[t] <= IDLE;
    end else begin
      for (int t = 0; t < 2; t++) state_q[t] <= state_d[t];
    end
  end

  // Next-state logic; INT with EN cleared leaves directly for IDLE
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      state_d[t] = state_q[t];
      case (state_q[t])
        IDLE: if (ctrl_q[t][0]) state_d[t] = LOAD;
        LOAD: state_d[t] = CNT;
        CNT: begin
          if (!ctrl_q[t][0])              state_d[t] = IDLE;
          else if (count_q[t] <= 32'd1)   state_d[t] = INT;
        end
        INT: begin
          if (!ctrl_q[t][0] || ctrl_q[t][2:1] != 2'd1) state_d[t] = IDLE;
          else                                         state_d[t] = LOAD;
        end
        default: state_d[t] = IDLE;
      endcase
    end
  end

  // Datapath next values; bus writes are applied last so software wins
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      ctrl_d[t]   = ctrl_q[t];
      preset_d[t] = preset_q[t];
      count_d[t]  = count_q[t];
      irq_d[t]    = irq_q[t];
      case (state_q[t])
        LOAD: count_d[t] = preset_q[t];
        CNT: begin
          if (ctrl_q[t][0]) begin
            if (count_q[t] <= 32'd1) begin
              count_d[t] = 32'd0;
              irq_d[t]   = 1'b1;
            end else begin
              count_d[t] = count_q[t] - 32'd1;
            end
          end
        end
        INT: if (ctrl_q[t][2:1] != 2'd1) ctrl_d[t][0] = 1'b0;
        default: ;
      endcase
      if (state_d[t] == LOAD && state_q[t] != LOAD) irq_d[t] = 1'b0;
      if (wr_ctrl[t]) begin
        ctrl_d[t] = ord[3:0];
        irq_d[t]  = 1'b0;
      end
      if (wr_preset[t]) begin
        preset_d[t] = ord;
        irq_d[t]    = 1'b0;
      end
    end
  end

  // Register file and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < 2; t++) begin
        ctrl_q[t]   <= 4'd0;
        preset_q[t] <= 32'd0;
        count_q[t]  <= 32'd0;
        irq_q[t]    <= 1'b0;
      end
    end else begin
      for (int t = 0; t < 2; t++) begin
        ctrl_q[t]   <= ctrl_d[t];
        preset_q[t] <= preset_d[t];
        count_q[t]  <= count_d[t];
        irq_q[t]    <= irq_d[t];
      end
    end
  end

endmodule

// File: tb/tb_timer_bridge.sv
// Directed bench for timer_bridge: register-access vector table plus
// hand-written multi-cycle timer sequences.
module tb_timer_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] oadd = 32'd0;
  logic [31:0] ord = 32'd0;
  logic        owe = 1'b0;
  logic [31:0] owd;
  logic        hit0;
  logic [5:0]  hwint;

  int checks = 0;
  int errors = 0;

  timer_bridge dut (
    .clk   (clk),
    .reset (reset),
    .oadd  (oadd),
    .ord   (ord),
    .owe   (owe),
    .owd   (owd),
    .hit0  (hit0),
    .hwint (hwint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [31:0] exp_owd;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    oadd = a;
    ord  = d;
    owe  = 1'b1;
    tick();
    owe  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    oadd = a;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{32'h7F00, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[1]  = '{32'h7F04, 32'h12345678, 1'b1, 32'h0,        1'b1};
    vecs[2]  = '{32'h7F04, 32'h0,        1'b0, 32'h12345678, 1'b1};
    vecs[3]  = '{32'h7F00, 32'hFFFFFFF6, 1'b1, 32'h0,        1'b1};
    vecs[4]  = '{32'h7F00, 32'h0,        1'b0, 32'h6,        1'b1};
    vecs[5]  = '{32'h7F08, 32'h1234,     1'b1, 32'h0,        1'b1};
    vecs[6]  = '{32'h7F08, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[7]  = '{32'h7F0C, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[8]  = '{32'h7F20, 32'h0,        1'b0, 32'h0,        1'b0};
    vecs[9]  = '{32'h7F14, 32'hA5,       1'b1, 32'h0,        1'b1};
    vecs[10] = '{32'h7F14, 32'h0,        1'b0, 32'hA5,       1'b1};
    vecs[11] = '{32'h7F04, 32'h0,        1'b0, 32'h12345678, 1'b1};
    vecs[12] = '{32'h7F1C, 32'hDEAD,     1'b1, 32'h0,        1'b0};
    vecs[13] = '{32'h7F18, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[14] = '{32'h00FF7F00, 32'h0,    1'b0, 32'h0,        1'b0};
    vecs[15] = '{32'h7F00, 32'h0,        1'b1, 32'h6,        1'b1};
    vecs[16] = '{32'h7F00, 32'h0,        1'b0, 32'h0,        1'b1};

    // Reset state, with decode live during reset
    #2;
    reset = 1'b1;
    #1;
    check("rst_hwint", {26'd0, hwint}, 32'd0);
    rd(32'h7F04);
    check("rst_hit_preset0", {31'd0, hit0}, 32'd1);
    check("rst_preset0", owd, 32'd0);
    rd(32'h7F18);
    check("rst_count1", owd, 32'd0);
    reset = 1'b0;
    tick();

    // Register access table
    for (int i = 0; i < 17; i++) begin
      oadd = vecs[i].addr;
      ord  = vecs[i].data;
      owe  = vecs[i].we;
      #1;
      check($sformatf("vec%0d_owd", i), owd, vecs[i].exp_owd);
      check($sformatf("vec%0d_hit", i), {31'd0, hit0}, {31'd0, vecs[i].exp_hit});
      check($sformatf("vec%0d_hwint", i), {26'd0, hwint}, 32'd0);
      tick();
      owe = 1'b0;
    end

    // One-shot countdown from 5 with interrupt hold
    do_reset();
    wr(32'h7F04, 32'd5);
    wr(32'h7F00, 32'h9);
    rd(32'h7F08);
    tick();
    check("t0_load_count", owd, 32'd0);
    tick();
    check("t0_count5", owd, 32'd5);
    tick();
    check("t0_count4", owd, 32'd4);
    tick();
    check("t0_count3", owd, 32'd3);
    rd(32'h7F20);
    check("unmapped_hit", {31'd0, hit0}, 32'd0);
    check("unmapped_owd", owd, 32'd0);
    wr(32'h7F08, 32'h1234);
    rd(32'h7F08);
    check("count_wr_ignored", owd, 32'd2);
    check("count_read_hit", {31'd0, hit0}, 32'd1);
    tick();
    check("t0_count1", owd, 32'd1);
    check("t0_noirq_yet", {26'd0, hwint}, 32'd0);
    tick();
    check("t0_count0", owd, 32'd0);
    check("t0_irq", {26'd0, hwint}, 32'd1);
    tick();
    rd(32'h7F00);
    check("t0_ctrl_en_cleared", owd, 32'h8);
    for (int i = 0; i < 5; i++) tick();
    check("t0_irq_held", {26'd0, hwint}, 32'd1);
    rd(32'h7F08);
    check("t0_count_stays0", owd, 32'd0);
    wr(32'h7F00, 32'h8);
    check("t0_irq_cleared_by_wr", {26'd0, hwint}, 32'd0);

    // Auto-reload on timer1: pulse every 5 edges
    do_reset();
    wr(32'h7F14, 32'd3);
    wr(32'h7F10, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("t1_pulse_e%0d", k), {26'd0, hwint},
            ((k % 5 == 0) ? 32'd2 : 32'd0));
    end
    wr(32'h7F10, 32'h8);
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("t1_stop_noirq", {26'd0, hwint}, 32'd0);
    rd(32'h7F18);
    check("t1_stop_count_held", owd, 32'd2);

    // PRESET=0: immediate expiry without wrap
    do_reset();
    wr(32'h7F04, 32'd0);
    wr(32'h7F00, 32'h9);
    rd(32'h7F08);
    tick();
    tick();
    check("p0_cnt_count", owd, 32'd0);
    check("p0_cnt_noirq", {26'd0, hwint}, 32'd0);
    tick();
    check("p0_int_count", owd, 32'd0);
    check("p0_int_irq", {26'd0, hwint}, 32'd1);
    tick();
    check("p0_nowrap", owd, 32'd0);

    // Software CTRL write in INT beats the hardware EN clear
    do_reset();
    wr(32'h7F04, 32'd2);
    wr(32'h7F00, 32'h9);
    for (int i = 0; i < 4; i++) tick();
    check("sw_win_int_irq", {26'd0, hwint}, 32'd1);
    wr(32'h7F00, 32'h9);
    rd(32'h7F00);
    check("sw_win_ctrl", owd, 32'h9);
    check("sw_win_irq_clr", {26'd0, hwint}, 32'd0);
    tick();
    tick();
    rd(32'h7F08);
    check("sw_win_reload", owd, 32'd2);

    // Asynchronous reset mid-count
    do_reset();
    wr(32'h7F04, 32'd200);
    wr(32'h7F00, 32'h9);
    rd(32'h7F08);
    for (int i = 0; i < 102; i++) tick();
    check("ar_count100", owd, 32'd100);
    #2;
    reset = 1'b1;
    #1;
    check("ar_count_cleared", owd, 32'd0);
    check("ar_hwint", {26'd0, hwint}, 32'd0);
    rd(32'h7F00);
    check("ar_ctrl_cleared", owd, 32'd0);
    rd(32'h7F04);
    check("ar_preset_cleared", owd, 32'd0);
    reset = 1'b0;
    rd(32'h7F08);
    for (int i = 0; i < 250; i++) tick();
    check("ar_no_irq_after", {26'd0, hwint}, 32'd0);
    check("ar_stays_idle", owd, 32'd0);

    // Simultaneous expiry of both timers
    do_reset();
    wr(32'h7F04, 32'd4);
    wr(32'h7F14, 32'd3);
    wr(32'h7F00, 32'h9);
    wr(32'h7F10, 32'h9);
    for (int i = 0; i < 4; i++) tick();
    check("both_before", {26'd0, hwint}, 32'd0);
    tick();
    check("both_same_edge", {26'd0, hwint}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
